// File: rtl/toggle_cover_collector.sv
// Sticky toggle-coverage bitmap with distinct-hit counter and a valid/ready
// word stream that dumps a snapshot of the bitmap on request.

module toggle_cover_lane #(
  parameter int OUT_W = 32,
  parameter int PC_W  = 6
) (
  input  logic [OUT_W-1:0] valid,
  input  logic [OUT_W-1:0] bitmap,
  input  logic             enable,
  output logic [OUT_W-1:0] hits,
  output logic [OUT_W-1:0] fresh,
  output logic [PC_W-1:0]  hits_cnt,
  output logic [PC_W-1:0]  fresh_cnt
);
  always_comb begin
    hits      = valid & {OUT_W{enable}};
    fresh     = hits & ~bitmap;
    hits_cnt  = '0;
    fresh_cnt = '0;
    for (int i = 0; i < OUT_W; i++) begin
      hits_cnt  = hits_cnt  + PC_W'(hits[i]);
      fresh_cnt = fresh_cnt + PC_W'(fresh[i]);
    end
  end
endmodule

module toggle_cover_collector #(
  parameter int WIDTH = 128,
  parameter int OUT_W = 32,
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] valid,
  input  logic             enable,
  input  logic             dump_req,
  input  logic             dump_clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_last,
  output logic             busy,
  output logic [CNT_W-1:0] hit_count,
  output logic             new_hit
);
  localparam int NW    = WIDTH / OUT_W;
  localparam int IW    = (NW > 1) ? $clog2(NW) : 1;
  localparam int PC_W  = $clog2(OUT_W + 1);
  localparam int SUM_W = $clog2(WIDTH + 1);
  localparam int EXT_W = ((CNT_W > SUM_W) ? CNT_W : SUM_W) + 1;
  localparam logic [EXT_W-1:0] CMAX = EXT_W'({CNT_W{1'b1}});
  localparam logic [IW-1:0]    LAST = IW'(NW - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                      state;
  logic [IW-1:0]               idx;
  logic [NW-1:0][OUT_W-1:0]    valid_w, bitmap, shadow, hits, fresh;
  logic [NW-1:0][PC_W-1:0]     hits_cnt, fresh_cnt;
  logic [SUM_W-1:0]            hits_sum, fresh_sum;

  assign valid_w = valid;

  for (genvar g = 0; g < NW; g++) begin : g_lane
    toggle_cover_lane #(.OUT_W(OUT_W), .PC_W(PC_W)) u_lane (
      .valid     (valid_w[g]),
      .bitmap    (bitmap[g]),
      .enable    (enable),
      .hits      (hits[g]),
      .fresh     (fresh[g]),
      .hits_cnt  (hits_cnt[g]),
      .fresh_cnt (fresh_cnt[g])
    );
  end

  always_comb begin
    hits_sum  = '0;
    fresh_sum = '0;
    for (int k = 0; k < NW; k++) begin
      hits_sum  = hits_sum  + SUM_W'(hits_cnt[k]);
      fresh_sum = fresh_sum + SUM_W'(fresh_cnt[k]);
    end
  end

  // Add in a width wide enough for both operands, then clamp.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [SUM_W-1:0] b);
    logic [EXT_W-1:0] s;
    s = EXT_W'(a) + EXT_W'(b);
    return (s > CMAX) ? CMAX[CNT_W-1:0] : s[CNT_W-1:0];
  endfunction

  assign out_data = shadow[idx];
  assign out_last = (state == SEND) && (idx == LAST);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      idx       <= '0;
      bitmap    <= '0;
      shadow    <= '0;
      hit_count <= '0;
      new_hit   <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      bitmap    <= bitmap | hits;
      hit_count <= sat_add(hit_count, fresh_sum);
      new_hit   <= |fresh;
      case (state)
        IDLE: if (dump_req) begin
          shadow    <= bitmap;
          idx       <= '0;
          state     <= SEND;
          out_valid <= 1'b1;
          busy      <= 1'b1;
          // Clear keeps this cycle's hits so no event is lost at the snapshot.
          if (dump_clear) begin
            bitmap    <= hits;
            hit_count <= sat_add('0, hits_sum);
            new_hit   <= |hits;
          end
        end
        SEND: if (out_ready) begin
          if (idx == LAST) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/toggle_cover_collector.md
Name: toggle_cover_collector

Overview:
Hardware-side sink for per-cycle toggle cover event vectors, intended for formal and emulation builds that have no DPI path. Each cycle it ORs the incoming event vector into a sticky coverage bitmap and counts how many distinct points are newly covered. On request it snapshots the bitmap and streams it out as fixed-width words over a valid/ready interface. It sits beside the toggle instrumentation and receives the same valid vector that the DPI reporter would consume.

Parameters:
WIDTH, 128, number of cover points (width of valid); must be a multiple of OUT_W.
OUT_W, 32, output word width.
CNT_W, 8, width of hit_count; must hold WIDTH, otherwise the count saturates.

Ports:
clock  input  1  clock; all state updates on posedge.
reset  input  1  synchronous reset, active-low.
valid  input  WIDTH  per-cycle cover event vector; bit i set means point i was hit this cycle.
enable  input  1  accumulate gate; when 0, valid is ignored.
dump_req  input  1  single-cycle request to snapshot the bitmap and stream it out.
dump_clear  input  1  sampled together with an accepted dump_req; when 1, the live bitmap and hit_count are cleared at the snapshot.
out_valid  output  1  output word available.
out_ready  input  1  consumer accepts the word when out_valid and out_ready are both 1.
out_data  output  OUT_W  snapshot word; word k is bits [k*OUT_W +: OUT_W].
out_last  output  1  high together with the final word (k = NW-1).
busy  output  1  dump in progress (state SEND).
hit_count  output  CNT_W  number of distinct points covered since reset or the last clear; saturating.
new_hit  output  1  registered pulse: at least one point was newly covered in the previous cycle.

Behaviour:
- NW = WIDTH/OUT_W (4 at the defaults). idx is a word index of width clog2(NW), minimum 1 bit.
- Reset (reset==0 at a clock edge):
  - bitmap, shadow, idx and hit_count go to 0; state goes to IDLE.
  - out_valid, out_last, busy and new_hit go to 0.
  - A reset mid-dump abandons the stream immediately with no out_last.
- Accumulation, every cycle in both states:
  - hits = valid & {WIDTH{enable}}.
  - fresh = hits & ~bitmap.
  - bitmap <= bitmap | hits.
  - hit_count <= min(hit_count + popcount(fresh), 2^CNT_W-1).
  - new_hit <= |fresh.
- FSM IDLE:
  - out_valid=0, busy=0.
  - On dump_req: shadow <= bitmap as it was before this cycle's OR. idx <= 0. Go to SEND.
  - If dump_clear is also 1: bitmap <= hits (not 0, so same-cycle hits are kept). hit_count <= popcount(hits). new_hit <= |hits.
- FSM SEND:
  - out_valid=1, busy=1, out_data=shadow word idx, out_last=(idx==NW-1).
  - On handshake: if idx==NW-1, go to IDLE; otherwise idx <= idx+1.
  - Without a handshake, out_data and out_last hold stable.
  - dump_req and dump_clear are ignored while in SEND.
- Latency: first word is valid the cycle after dump_req. With out_ready held high, a dump takes NW cycles. Back-to-back dumps are possible: a dump_req in the cycle after the last handshake is accepted.
- Hits arriving during SEND go to the live bitmap only; the shadow is unaffected.
- popcount and saturation use full-width arithmetic before the clamp, with no wrap-around.
- All outputs are registered except out_data and out_last, which are driven directly from the registered shadow and idx.

Test Plan:
- Reset release, then valid=0 for 10 cycles -> hit_count=0, new_hit=0, out_valid=0, busy=0.
- valid=bit0|bit127 for one cycle, then the same vector again -> hit_count=2 after the first cycle and still 2 after the repeat; new_hit pulses exactly once.
- Set bits 5 and 64, then dump_req with dump_clear=0 and out_ready=1 -> 4 words: 0x00000020, 0, 0x00000001, 0; out_last on the 4th word only; bitmap retained.
- Dump with out_ready toggling 1,0,0,1,... and dump_clear=1, with valid=bit3 in the same cycle as dump_req -> words held stable while out_ready=0; the stream contains the old bitmap without bit 3; afterwards hit_count=1 and a second dump shows word0=0x00000008.
- During SEND, drive valid=bit100 and pulse dump_req -> the current stream is unchanged and no second dump starts; hit_count increments by 1.
- reset low during word 2 of a dump -> next cycle out_valid=0, busy=0, hit_count=0, no out_last; a subsequent dump returns all-zero words.
- Saturation (CNT_W=4 override, WIDTH=128): cover 20 distinct bits -> hit_count=15 and holds.
